icache_direct: RTL and testbench
================================

// Module: icache_direct
// PURPOSE
//  Direct-mapped, one-word-per-frame instruction cache: responder side of the
//  datapath instruction-fetch port (imemREN/imemaddr -> ihit/imemload).
//  Hits return the instruction in the request cycle. Misses fetch the word
//  from the memory controller (iREN/iaddr -> iwait/iload), then fill the frame.
//  Sits between the pipelined datapath fetch stage and the memory controller.
// PARAMETERS
//  SETS      16   number of frames; power of 2, >=2; IDX = $clog2(SETS)
// PORTS
//  CLK          in   1   system clock; all state on posedge
//  RST          in   1   asynchronous, active-high reset
//  imemREN      in   1   datapath fetch request
//  imemaddr     in   32  datapath fetch byte address
//  ihit         out  1   requested word valid this cycle
//  imemload     out  32  instruction word; 0 when ihit=0
//  iREN         out  1   memory-controller read request
//  iaddr        out  32  memory-controller word address; bits [1:0] always 0
//  iwait        in   1   1 = memory busy; 0 with iREN=1 = iload valid
//  iload        in   32  fill data from memory
//  miss_count   out  32  number of misses since reset (saturating)
// BEHAVIOUR
//  Address split: [1:0] ignored; index=[IDX+1:2]; tag=[31:IDX+2].
//  Storage per frame: valid (1), tag (30-IDX), data (32).
//  Reset (async, RST=1): all valid<=0, state<=IDLE, miss_addr<=0,
//   miss_count<=0. Outputs follow immediately: ihit=0, imemload=0,
//   iREN=0, iaddr=0.
//  FSM, 2 states:
//   IDLE: hit = imemREN & valid[index] & tag match.
//    - On a hit: ihit=1 and imemload=data[index], combinationally in the
//      same cycle (zero-cycle latency).
//    - On imemREN & !hit: ihit=0, latch miss_addr={imemaddr[31:2],2'b00},
//      miss_count++ (hold at 32'hFFFFFFFF), next state FILL.
//    - With imemREN=0: no action. iREN=0.
//   FILL: iREN=1, iaddr=miss_addr, ihit=0 unconditionally.
//    - If iwait=0: write data, tag and valid=1 into the frame at
//      miss_addr's index, then go to IDLE.
//    - If iwait=1: stay in FILL.
//  Miss latency: 1 detect cycle + N FILL cycles (the last one has iwait=0).
//   ihit=1 the cycle after the fill, if the request is still present.
//  The fill always completes for the latched miss_addr. imemaddr or imemREN
//   may change or deassert during FILL (branch flush, stall); IDLE then
//   re-evaluates the new address.
//  Conflict: a fill replaces the frame unconditionally. There is no
//   write-back (instruction memory is read-only).
//  Simultaneous fill and hit in one cycle cannot occur (ihit=0 in FILL).
//  RST asserted mid-FILL: iREN drops asynchronously and the partial fill is
//   discarded.
//  No X propagation: imemload=0 whenever ihit=0.
// TESTING
//  1 Cold miss: reset, imemREN=1, addr 0x0 -> ihit=0. Next cycle iREN=1,
//    iaddr=0x0. Hold iwait=1 for 2 cycles, then iwait=0 with
//    iload=0x8C010004 -> next cycle ihit=1, imemload=0x8C010004,
//    miss_count=1.
//  2 Warm hit + offset: addr 0x0, then 0x2 -> ihit=1 in the same cycle each
//    time, iREN stays 0, miss_count stays 1. imemREN=0 -> ihit=0, no fill.
//  3 Conflict (SETS=16): fill 0x0, then request 0x40 (index 0) -> miss,
//    iaddr=0x40. Re-request 0x0 -> miss again, miss_count=3.
//  4 Addr change mid-FILL: miss on 0x8; switch imemaddr to 0x100 while
//    iwait=1 -> fill completes at index 2 with 0x8's data. 0x100 then misses
//    (iaddr=0x100). Later 0x8 hits.
//  5 Reset mid-FILL: RST=1 while iwait=1 -> iREN=0 the same cycle,
//    miss_count=0. After release, addr 0x0 misses again.
//  6 Saturation: force miss_count to 32'hFFFFFFFE, cause 3 misses ->
//    count reads 32'hFFFFFFFF.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one word per frame. Hits answer in the request
// cycle; misses run a blocking fill from the memory controller.
module icache_direct #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 30 - IDX;

  typedef enum logic {StIdle, StFill} state_t;

  state_t            state_q, state_d;
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic [31:0]       miss_count_q, miss_count_d;
  logic [SETS-1:0]   valid_q;
  logic [TAGW-1:0]   tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDX-1:0]    req_idx, fill_idx;
  logic [TAGW-1:0]   req_tag;
  logic              lookup_hit;
  logic              fill_we;

  assign req_idx  = imemaddr[IDX+1:2];
  assign req_tag  = imemaddr[31:IDX+2];
  assign fill_idx = miss_addr_q[IDX+1:2];

  // Lookup is gated by the state so a fill and a hit can never share a cycle.
  assign lookup_hit = (state_q == StIdle) & imemREN & valid_q[req_idx] &
                      (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    miss_count_d = miss_count_q;
    fill_we      = 1'b0;
    ihit         = 1'b0;
    imemload     = 32'h0;
    iREN         = 1'b0;
    iaddr        = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (lookup_hit) begin
          ihit     = 1'b1;
          imemload = data_q[req_idx];
        end else if (imemREN) begin
          miss_addr_d = {imemaddr[31:2], 2'b00};
          if (miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_d = miss_count_q + 32'd1;
          end
          state_d = StFill;
        end
      end
      StFill: begin
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) begin
          fill_we = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      miss_addr_q  <= 32'h0;
      miss_count_q <= 32'h0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      miss_count_q <= miss_count_d;
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data need no reset: valid qualifies them.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= miss_addr_q[31:IDX+2];
      data_q[fill_idx] <= iload;
    end
  end

  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed vector table, reset and
// saturation sequences, then random traffic against a word-address reference model.
module tb_icache_direct;

  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
  logic [31:0] miss_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  icache_direct #(.SETS(SETS)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  // Reference model: each frame remembers the full word address it holds.
  bit          m_valid [SETS];
  logic [29:0] m_word  [SETS];
  logic [31:0] m_data  [SETS];
  bit          m_filling;
  logic [31:0] m_miss_addr;
  logic [31:0] m_count;

  function automatic int frame_of(logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  function automatic bit m_hit();
    return !m_filling && imemREN && m_valid[frame_of(imemaddr)] &&
           (m_word[frame_of(imemaddr)] == imemaddr[31:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    m_filling   = 1'b0;
    m_miss_addr = 32'h0;
    m_count     = 32'h0;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model advance using the inputs present at the coming edge, then the edge itself.
  task automatic tick();
    if (RST) begin
      model_reset();
    end else if (m_filling) begin
      if (!iwait) begin
        m_valid[frame_of(m_miss_addr)] = 1'b1;
        m_word[frame_of(m_miss_addr)]  = m_miss_addr[31:2];
        m_data[frame_of(m_miss_addr)]  = iload;
        m_filling = 1'b0;
      end
    end else if (imemREN && !m_hit()) begin
      m_miss_addr = {imemaddr[31:2], 2'b00};
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      m_filling = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  // One model-checked cycle; fill data comes from the bench's own memory image.
  task automatic model_cycle(bit ren, logic [31:0] addr, bit iw);
    imemREN  = ren;
    imemaddr = addr;
    iwait    = iw;
    iload    = m_filling ? mem_word(m_miss_addr) : 32'hDEAD_BEEF;
    #3;
    chk("m_ihit", {31'h0, ihit}, {31'h0, m_hit()});
    chk("m_imemload", imemload, m_hit() ? m_data[frame_of(addr)] : 32'h0);
    chk("m_iREN", {31'h0, iREN}, {31'h0, m_filling});
    chk("m_iaddr", iaddr, m_filling ? m_miss_addr : 32'h0);
    chk("m_miss_count", miss_count, m_count);
    tick();
  endtask

  typedef struct {
    bit          ren;
    logic [31:0] addr;
    bit          iw;
    logic [31:0] ld;
    bit          e_hit;
    logic [31:0] e_load;
    bit          e_iren;
    logic [31:0] e_iaddr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [19];

  initial begin
    //          ren addr        iw ld            hit load          iren iaddr      cnt
    vecs[0]  = '{1, 32'h0,   1, 32'h0,        0, 32'h0,        0, 32'h0,   32'd0};
    vecs[1]  = '{1, 32'h0,   1, 32'h0,        0, 32'h0,        1, 32'h0,   32'd1};
    vecs[2]  = '{1, 32'h0,   1, 32'h0,        0, 32'h0,        1, 32'h0,   32'd1};
    vecs[3]  = '{1, 32'h0,   0, 32'h8C010004, 0, 32'h0,        1, 32'h0,   32'd1};
    vecs[4]  = '{1, 32'h0,   1, 32'h0,        1, 32'h8C010004, 0, 32'h0,   32'd1};
    vecs[5]  = '{1, 32'h2,   1, 32'h0,        1, 32'h8C010004, 0, 32'h0,   32'd1};
    vecs[6]  = '{0, 32'h0,   1, 32'h0,        0, 32'h0,        0, 32'h0,   32'd1};
    vecs[7]  = '{1, 32'h40,  1, 32'h0,        0, 32'h0,        0, 32'h0,   32'd1};
    vecs[8]  = '{1, 32'h40,  0, 32'h11111111, 0, 32'h0,        1, 32'h40,  32'd2};
    vecs[9]  = '{1, 32'h40,  1, 32'h0,        1, 32'h11111111, 0, 32'h0,   32'd2};
    vecs[10] = '{1, 32'h0,   1, 32'h0,        0, 32'h0,        0, 32'h0,   32'd2};
    vecs[11] = '{1, 32'h0,   0, 32'h8C010004, 0, 32'h0,        1, 32'h0,   32'd3};
    vecs[12] = '{1, 32'h0,   1, 32'h0,        1, 32'h8C010004, 0, 32'h0,   32'd3};
    vecs[13] = '{1, 32'h8,   1, 32'h0,        0, 32'h0,        0, 32'h0,   32'd3};
    vecs[14] = '{1, 32'h100, 1, 32'h0,        0, 32'h0,        1, 32'h8,   32'd4};
    vecs[15] = '{1, 32'h100, 0, 32'h22222222, 0, 32'h0,        1, 32'h8,   32'd4};
    vecs[16] = '{1, 32'h100, 1, 32'h0,        0, 32'h0,        0, 32'h0,   32'd4};
    vecs[17] = '{1, 32'h100, 0, 32'h33333333, 0, 32'h0,        1, 32'h100, 32'd5};
    vecs[18] = '{1, 32'h8,   1, 32'h0,        1, 32'h22222222, 0, 32'h0,   32'd5};

    model_reset();
    #3;
    chk("rst_ihit", {31'h0, ihit}, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iREN", {31'h0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_miss_count", miss_count, 32'h0);
    tick();
    tick();
    RST = 1'b0;

    foreach (vecs[i]) begin
      imemREN  = vecs[i].ren;
      imemaddr = vecs[i].addr;
      iwait    = vecs[i].iw;
      iload    = vecs[i].ld;
      #3;
      chk($sformatf("v%0d_ihit", i), {31'h0, ihit}, {31'h0, vecs[i].e_hit});
      chk($sformatf("v%0d_imemload", i), imemload, vecs[i].e_load);
      chk($sformatf("v%0d_iREN", i), {31'h0, iREN}, {31'h0, vecs[i].e_iren});
      chk($sformatf("v%0d_iaddr", i), iaddr, vecs[i].e_iaddr);
      chk($sformatf("v%0d_miss_count", i), miss_count, vecs[i].e_cnt);
      tick();
    end

    // Reset in the middle of a fill.
    imemREN  = 1'b1;
    imemaddr = 32'h4;
    iwait    = 1'b1;
    #3;
    tick();
    chk("fill_started_iREN", {31'h0, iREN}, 32'h1);
    RST = 1'b1;
    #1;
    chk("midfill_rst_iREN", {31'h0, iREN}, 32'h0);
    chk("midfill_rst_iaddr", iaddr, 32'h0);
    chk("midfill_rst_count", miss_count, 32'h0);
    tick();
    RST = 1'b0;
    imemaddr = 32'h0;
    #3;
    chk("post_rst_miss_ihit", {31'h0, ihit}, 32'h0);
    tick();
    chk("post_rst_iREN", {31'h0, iREN}, 32'h1);
    chk("post_rst_count", miss_count, 32'h1);
    model_cycle(1'b1, 32'h0, 1'b0);
    model_cycle(1'b1, 32'h0, 1'b1);

    // Saturation: preload the counter close to its ceiling.
    force dut.miss_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.miss_count_q;
    m_count = 32'hFFFF_FFFE;
    for (int k = 1; k <= 3; k++) begin
      model_cycle(1'b1, 32'h1000 * k, 1'b1);
      model_cycle(1'b1, 32'h1000 * k, 1'b0);
    end
    #3;
    chk("sat_count", miss_count, 32'hFFFF_FFFF);
    tick();

    // Random traffic over a small address pool so conflicts and re-hits are common.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 47) << 2) | $urandom_range(0, 3);
      model_cycle($urandom_range(0, 9) < 8, a, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
